// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice, carry flop, operand and result shift registers.
// Optional signed-overflow output compiled in with `define SERIAL_OVF_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cout_reg;
`ifdef SERIAL_OVF_EN
    logic             ovf_reg;
`endif

    logic s_next;
    logic carry_next;
    logic last_bit;
    logic accept;

    // Shared one-bit full-adder slice.
    always_comb begin
        s_next     = a_reg[0] ^ b_reg[0] ^ carry_reg;
        carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
        last_bit   = (cnt_reg == CW'(WIDTH - 1));
        accept     = start && (state_reg != SHIFT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
`ifdef SERIAL_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with sub.
            state_reg <= SHIFT;
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
`ifdef SERIAL_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                SHIFT: begin
                    a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
                    sum_reg   <= {s_next, sum_reg[WIDTH-1:1]};
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        state_reg <= DONE;
                        cout_reg  <= carry_next;
`ifdef SERIAL_OVF_EN
                        // carry_reg here is the carry into the MSB slice.
                        ovf_reg   <= carry_reg ^ carry_next;
`endif
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
`ifdef SERIAL_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed cases plus random operations
// checked against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_OVF_EN
    logic         ovf;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain modular arithmetic on integers.
    task automatic model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                         output logic [W-1:0] es, output logic ec, output logic eo);
        int unsigned full;
        if (si) begin
            full = int'(ai) + 256 - int'(bi);
            ec   = (ai >= bi);
        end else begin
            full = int'(ai) + int'(bi);
            ec   = (full > 255);
        end
        es = full[W-1:0];
        if (si) eo = (ai[W-1] != bi[W-1]) && (es[W-1] != ai[W-1]);
        else    eo = (ai[W-1] == bi[W-1]) && (es[W-1] != ai[W-1]);
    endtask

    // Called at a negedge; drives start there and follows the whole operation.
    // Returns at the negedge inside the DONE cycle. inject>=0 pulses a stray start in SHIFT.
    task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic si, input int inject);
        logic [W-1:0] es;
        logic ec, eo;
        int nbusy;
        model(ai, bi, si, es, ec, eo);
        start = 1'b1; a = ai; b = bi; sub = si;
        @(negedge Clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        nbusy = 0;
        for (int i = 0; i < W; i++) begin
            if (busy === 1'b1) nbusy++;
            if (done !== 1'b0) chk({tag, "_done_early"}, {31'b0, done}, 32'd0);
            if (i == inject) begin
                start = 1'b1; a = 8'h11;
            end else if (i == inject + 1) begin
                start = 1'b0;
            end
            @(negedge Clk);
        end
        chk({tag, "_busy_cycles"}, nbusy, W);
        chk({tag, "_done"}, {30'b0, busy, done}, 32'd1);
        chk({tag, "_sum"}, {24'b0, sum}, {24'b0, es});
        chk({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
`ifdef SERIAL_OVF_EN
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
`endif
        $display("[TB] %s a=%02h b=%02h sub=%0d -> sum=%02h cout=%0d (exp %02h/%0d)",
                 tag, ai, bi, si, sum, cout, es, ec);
    endtask

    // Step out of DONE with start low: strobe must drop, result must hold.
    task automatic leave_done(input string tag);
        logic [W-1:0] held;
        held = sum;
        @(negedge Clk);
        chk({tag, "_done_drop"}, {30'b0, busy, done}, 32'd0);
        chk({tag, "_sum_hold"}, {24'b0, sum}, {24'b0, held});
    endtask

    initial begin
        int ndone;
        Reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;
        chk("reset_state", {28'b0, busy, done, cout, |sum}, 32'd0);
`ifdef SERIAL_OVF_EN
        chk("reset_ovf", {31'b0, ovf}, 32'd0);
`endif
        @(negedge Clk);

        run_op("add", 8'h3C, 8'h05, 1'b0, -1);
        leave_done("add");
        run_op("add_wrap", 8'hFF, 8'h01, 1'b0, -1);
        leave_done("add_wrap");
        run_op("add_sovf", 8'h7F, 8'h01, 1'b0, -1);
        leave_done("add_sovf");

        run_op("sub_borrow", 8'h05, 8'h07, 1'b1, -1);
        run_op("sub_b2b", 8'h07, 8'h05, 1'b1, -1);
        leave_done("sub_b2b");

        run_op("ignored_start", 8'h3C, 8'h05, 1'b0, 3);
        leave_done("ignored_start");
        chk("ignored_no_rerun", {31'b0, busy}, 32'd0);

        // Reset during SHIFT cycle 4 aborts the operation.
        start = 1'b1; a = 8'h3C; b = 8'h05; sub = 1'b0;
        @(negedge Clk);
        start = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("rst_mid_state", {29'b0, busy, done, cout}, 32'd0);
        chk("rst_mid_sum", {24'b0, sum}, 32'd0);
        ndone = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge Clk);
            if (done === 1'b1) ndone++;
        end
        chk("rst_no_done", ndone, 0);
        run_op("after_reset", 8'h10, 8'h20, 1'b0, -1);
        leave_done("after_reset");

        for (int k = 0; k < 24; k++) begin
            run_op($sformatf("rand%0d", k), W'($urandom), W'($urandom), 1'($urandom), -1);
            if ($urandom_range(0, 1) == 0) leave_done($sformatf("rand%0d", k));
        end
        leave_done("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract sequencer built around a one-bit full-adder slice and flip-flop storage: a carry flip-flop plus operand and result shift registers. On a `start` pulse it captures two WIDTH-bit operands, runs the shared adder slice for exactly WIDTH cycles (LSB first), and then presents the result with a one-cycle `done` strobe. It is the control and sequencing layer for the flip-flop-based serial arithmetic datapath.

## Interface
- `WIDTH`, default 8: operand and result width in bits, WIDTH ≥ 2.
- `Clk`  input  1  rising-edge clock.
- `Reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request pulse; accepted only when `busy`=0.
- `sub`  input  1  0 selects A+B; 1 selects A−B; sampled with `start`.
- `a`  input  WIDTH  operand A; sampled with `start`.
- `b`  input  WIDTH  operand B; sampled with `start`.
- `busy`  output  1  high while a serial operation is in progress.
- `done`  output  1  one-cycle strobe; `sum` and `cout` are valid.
- `sum`  output  WIDTH  result register; held until the next accepted `start`.
- `cout`  output  1  final carry out; for subtraction, 1 means no borrow.
- `ovf`  output  1  signed overflow; present only with `SERIAL_OVF_EN` (see Configuration).

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - SHIFT: `busy`=1.
  - DONE: `busy`=0, `done`=1.
- Accept: in IDLE or DONE with `start`=1 on a rising edge:
  - A_reg ← `a`.
  - B_reg ← `b` when `sub`=0, or ~`b` when `sub`=1.
  - carry ← `sub`.
  - bit counter ← 0; `sum` ← 0; `cout` ← 0.
  - Next state is SHIFT.
- SHIFT, each cycle:
  - s = A_reg[0] ^ B_reg[0] ^ carry; carry ← majority(A_reg[0], B_reg[0], carry).
  - A_reg and B_reg shift right by one.
  - `sum` shifts right with s entering at bit WIDTH−1.
  - Counter increments. After the cycle with counter = WIDTH−1, go to DONE and load `cout` from the final carry.
- DONE: lasts one cycle. With `start`=0 go to IDLE; with `start`=1 accept a new operation exactly as in IDLE.
- `start` in SHIFT is ignored and has no side effects. `sub`, `a` and `b` may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH. `cout` is the carry out of the MSB, using two's-complement for subtraction.
- Counter width is $clog2(WIDTH)+1; the counter never wraps within a single operation.

## Timing
- Reset (synchronous, highest priority over `start`): state=IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0; internal registers 0.
- If `start` is accepted on edge t:
  - `busy`=1 from t through edge t+WIDTH.
  - `done`=1 for the single cycle after edge t+WIDTH.
  - Total latency is WIDTH+1 edges from `start` to the `done` edge.
- Back-to-back operation: `start` high during the DONE cycle begins the next operation with no idle gap. `done` then lasts exactly one cycle.
- Reset mid-SHIFT aborts the operation. The next cycle shows the reset values and no `done` is ever issued for the aborted operation.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

## Configuration
- `SERIAL_OVF_EN` defined:
  - `ovf` port and its logic are compiled in.
  - `ovf` = (carry into MSB) XOR (carry out of MSB). It is registered together with `cout` on entry to DONE, cleared on accept, and held until then.
- `SERIAL_OVF_EN` undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
All cases use WIDTH=8.
- Add: `a`=8'h3C, `b`=8'h05, `sub`=0, `start` at edge t → `busy` high for 8 cycles; `done` after edge t+8; `sum`=8'h41, `cout`=0.
- Add with wrap: `a`=8'hFF, `b`=8'h01, `sub`=0 → `sum`=8'h00, `cout`=1, `ovf`=0.
- Signed overflow (with `SERIAL_OVF_EN`): `a`=8'h7F, `b`=8'h01, `sub`=0 → `sum`=8'h80, `cout`=0, `ovf`=1.
- Subtract with borrow: `a`=8'h05, `b`=8'h07, `sub`=1 → `sum`=8'hFE, `cout`=0. Then `start` again in the DONE cycle with `a`=8'h07, `b`=8'h05, `sub`=1 → `sum`=8'h02, `cout`=1, with exactly 8 busy cycles and no idle gap.
- Ignored start: pulse `start` with `a`=8'h11 during SHIFT cycle 3 of an 8'h3C+8'h05 operation → result is still 8'h41, `done` timing is unchanged, and no second operation runs.
- Reset mid-operation: assert `Reset` for one cycle at SHIFT cycle 4 → next cycle has `busy`=0, `sum`=0, `cout`=0, and `done` never pulses. A subsequent `start` with 8'h10+8'h20 → `sum`=8'h30 after 9 edges.
